// File: rtl/riscv_pkg.sv
// Shared memory-op encodings and decode helpers for the decoder and the load/store unit.
package riscv_pkg;

    localparam logic [4:0] MEMOFF     = 5'd0;
    localparam logic [4:0] LBYTE      = 5'd1;
    localparam logic [4:0] LHALFWORD  = 5'd2;
    localparam logic [4:0] LWORD      = 5'd3;
    localparam logic [4:0] LBYTEU     = 5'd4;
    localparam logic [4:0] LHALFWORDU = 5'd5;
    localparam logic [4:0] SBYTE      = 5'd6;
    localparam logic [4:0] SHALFWORD  = 5'd7;
    localparam logic [4:0] SWORD      = 5'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_t;

    function automatic logic op_is_load(input logic [4:0] op);
        case (op)
            LBYTE, LHALFWORD, LWORD, LBYTEU, LHALFWORDU: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [4:0] op);
        case (op)
            SBYTE, SHALFWORD, SWORD: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic op_misaligned(input logic [4:0] op, input logic [1:0] off);
        case (op)
            LHALFWORD, LHALFWORDU, SHALFWORD: return off[0];
            LWORD, SWORD:                     return (off != 2'b00);
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_ctrl_if;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        input  dbus_gnt, dbus_rvalid, dbus_rdata
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
        output dbus_gnt, dbus_rvalid, dbus_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables/replication and load extraction/extension.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [4:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  logic [4:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted_s;

    // Store side: enables follow the address lane, data is replicated on every lane.
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = 32'h0000_0000;
        case (st_op)
            SBYTE: begin
                st_be    = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            SHALFWORD: begin
                st_be    = 4'b0011 << {st_off[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            SWORD: begin
                st_be    = 4'b1111;
                st_lanes = st_data;
            end
            default: begin
                st_be    = 4'b0000;
                st_lanes = 32'h0000_0000;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted_s = ld_word >> {ld_off, 3'b000};
        case (ld_op)
            LBYTE:      ld_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LBYTEU:     ld_data = {24'h00_0000, shifted_s[7:0]};
            LHALFWORD:  ld_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LHALFWORDU: ld_data = {16'h0000, shifted_s[15:0]};
            LWORD:      ld_data = ld_word;
            default:    ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request/grant/response bus transaction per memory op, with stall,
// misalignment rejection and bus timeout.
module lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [4:0]    mem_op,
    input  logic [31:0]   addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] rdata,
    output logic          rdata_valid,
    output logic          misalign,
    output logic          bus_err,
    lsu_ctrl_if.master    dbus
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state_r;
    logic [4:0]    op_r;
    logic [1:0]    off_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   rdata_r;
    logic          rdata_valid_r;
    logic          req_r;
    logic          we_r;
    logic [31:0]   daddr_r;
    logic [3:0]    be_r;
    logic [31:0]   dwdata_r;

    logic          op_ok_s;
    logic          op_mis_s;
    logic          idle_s;
    logic          go_s;
    logic          busy_s;
    logic          timeout_s;
    logic [3:0]    st_be_s;
    logic [31:0]   st_lanes_s;
    logic [31:0]   ld_data_s;

    lsu_align u_align (
        .st_op    (mem_op),
        .st_off   (addr[1:0]),
        .st_data  (wdata),
        .st_be    (st_be_s),
        .st_lanes (st_lanes_s),
        .ld_op    (op_r),
        .ld_off   (off_r),
        .ld_word  (dbus.dbus_rdata),
        .ld_data  (ld_data_s)
    );

    // Decode of the incoming op; unknown codes fall out as neither load nor store.
    always_comb begin
        op_ok_s   = op_is_load(mem_op) || op_is_store(mem_op);
        op_mis_s  = op_ok_s && op_misaligned(mem_op, addr[1:0]);
        idle_s    = (state_r == ST_IDLE);
        go_s      = idle_s && op_ok_s && !op_mis_s;
        busy_s    = (state_r == ST_REQ) || (state_r == ST_WAIT);
        timeout_s = busy_s && (cnt_r == CNT_LAST);
    end

    // Stall and misalign are gated by reset so a held instruction cannot raise them in reset.
    assign stall            = rst_n && (go_s || busy_s);
    assign misalign         = rst_n && idle_s && op_mis_s;
    assign bus_err          = timeout_s;
    assign rdata            = rdata_r;
    assign rdata_valid      = rdata_valid_r;
    assign dbus.dbus_req    = req_r;
    assign dbus.dbus_we     = we_r;
    assign dbus.dbus_addr   = daddr_r;
    assign dbus.dbus_be     = be_r;
    assign dbus.dbus_wdata  = dwdata_r;

    // Transaction FSM with its registered bus, result and timeout state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            op_r          <= MEMOFF;
            off_r         <= 2'b00;
            cnt_r         <= '0;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            req_r         <= 1'b0;
            we_r          <= 1'b0;
            daddr_r       <= 32'h0000_0000;
            be_r          <= 4'b0000;
            dwdata_r      <= 32'h0000_0000;
        end else begin
            rdata_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        op_r     <= mem_op;
                        off_r    <= addr[1:0];
                        cnt_r    <= '0;
                        req_r    <= 1'b1;
                        we_r     <= op_is_store(mem_op);
                        daddr_r  <= {addr[31:2], 2'b00};
                        be_r     <= st_be_s;
                        dwdata_r <= st_lanes_s;
                        state_r  <= ST_REQ;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (timeout_s || dbus.dbus_gnt) begin
                        req_r    <= 1'b0;
                        we_r     <= 1'b0;
                        daddr_r  <= 32'h0000_0000;
                        be_r     <= 4'b0000;
                        dwdata_r <= 32'h0000_0000;
                    end else begin
                        req_r    <= 1'b1;
                    end
                    // Timeout wins over a grant arriving in the same cycle.
                    if (timeout_s) begin
                        rdata_r <= 32'h0000_0000;
                        state_r <= ST_DONE;
                    end else if (dbus.dbus_gnt) begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= op_is_store(op_r) ? ST_DONE : ST_WAIT;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (timeout_s) begin
                        rdata_r <= 32'h0000_0000;
                        state_r <= ST_DONE;
                    end else if (dbus.dbus_rvalid) begin
                        rdata_r       <= ld_data_s;
                        rdata_valid_r <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table driven through a bus responder, load results
// checked through a scoreboard queue, plus reset-in-flight sequence.
module tb_lsu_ctrl;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;

    lsu_ctrl_if dbus_if ();

    lsu_ctrl #(.DW(32), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_op      (mem_op),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .dbus        (dbus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          gnt_delay;   // -1: never grant
        logic        exp_mis;
        logic        exp_req;
        logic        exp_we;
        logic [31:0] exp_daddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_dwdata;
        logic        exp_rv;
        logic [31:0] exp_rdata;
        logic        exp_berr;
        int          exp_stall;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] brd, input int gd, input logic mis, input logic req,
                       input logic we, input logic [31:0] da, input logic [3:0] be,
                       input logic [31:0] dwd, input logic rv, input logic [31:0] rd,
                       input logic be_err, input int st);
        vec_t v;
        v = '{op, a, wd, brd, gd, mis, req, we, da, be, dwd, rv, rd, be_err, st};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   req_cnt = 0;
        int   stall_cnt = 0;
        int   mis_cnt = 0;
        int   rv_cnt = 0;
        int   berr_cnt = 0;
        int   berr_at = 0;
        logic prev_stall = 1'b0;
        logic pend_rv = 1'b0;
        logic fields_done = 1'b0;
        logic finished = 1'b0;
        logic [31:0] done_rdata = 32'h0;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.exp_rv) sb_q.push_back(v.exp_rdata);
        for (int cyc = 0; cyc < 30 && !finished; cyc++) begin
            @(negedge clk);
            mem_op = v.op;
            addr   = v.addr;
            wdata  = v.wdata;
            dbus_if.dbus_gnt    = dbus_if.dbus_req && (v.gnt_delay >= 0) && (req_cnt == v.gnt_delay);
            dbus_if.dbus_rvalid = pend_rv;
            dbus_if.dbus_rdata  = pend_rv ? v.bus_rdata : 32'h5A5A_5A5A;
            pend_rv = dbus_if.dbus_gnt && !v.exp_we;
            #1;
            if (dbus_if.dbus_req) begin
                req_cnt++;
                if (!fields_done) begin
                    fields_done = 1'b1;
                    chk({tag, "_we"}, {31'h0, dbus_if.dbus_we}, {31'h0, v.exp_we});
                    chk({tag, "_daddr"}, dbus_if.dbus_addr, v.exp_daddr);
                    if (v.exp_we) begin
                        chk({tag, "_be"}, {28'h0, dbus_if.dbus_be}, {28'h0, v.exp_be});
                        chk({tag, "_dwdata"}, dbus_if.dbus_wdata, v.exp_dwdata);
                    end
                end
            end
            if (stall) stall_cnt++;
            if (misalign) mis_cnt++;
            if (bus_err) begin
                berr_cnt++;
                berr_at = req_cnt;
            end
            if (rdata_valid) begin
                rv_cnt++;
                if (sb_q.size() == 0) begin
                    chk({tag, "_rv_unexpected"}, 32'd1, 32'd0);
                end else begin
                    chk({tag, "_rdata"}, rdata, sb_q.pop_front());
                end
            end
            if ((cyc == 0 && !stall) || (prev_stall && !stall)) begin
                finished   = 1'b1;
                done_rdata = rdata;
            end
            prev_stall = stall;
        end
        if (!finished) chk({tag, "_no_completion"}, 32'd1, 32'd0);
        chk({tag, "_misalign"}, mis_cnt, {31'h0, v.exp_mis});
        chk({tag, "_stall_cycles"}, stall_cnt, v.exp_stall);
        chk({tag, "_req_seen"}, {31'h0, (req_cnt > 0)}, {31'h0, v.exp_req});
        chk({tag, "_rv_count"}, rv_cnt, {31'h0, v.exp_rv});
        chk({tag, "_bus_err"}, berr_cnt, {31'h0, v.exp_berr});
        if (v.exp_berr) begin
            chk({tag, "_berr_cycle"}, berr_at, 32'd4);
            chk({tag, "_berr_rdata"}, done_rdata, 32'h0);
            chk({tag, "_berr_req_drop"}, {31'h0, dbus_if.dbus_req}, 32'h0);
        end
        mem_op = MEMOFF;
        dbus_if.dbus_gnt = 1'b0;
        dbus_if.dbus_rvalid = 1'b0;
    endtask

    initial begin
        vec_t rv;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        mem_op = MEMOFF;
        addr = 32'h0;
        wdata = 32'h0;
        dbus_if.dbus_gnt = 1'b0;
        dbus_if.dbus_rvalid = 1'b0;
        dbus_if.dbus_rdata = 32'h0;

        //  op          addr          wdata         bus rdata     gnt mis req we daddr         be       dwdata        rv rdata         berr stall
        add(SWORD,      32'h100, 32'hDEAD_BEEF, 32'h0,         0, 0, 1, 1, 32'h100, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0,         0, 2);
        add(SBYTE,      32'h103, 32'h0000_00A5, 32'h0,         0, 0, 1, 1, 32'h100, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0,         0, 2);
        add(SHALFWORD,  32'h202, 32'h1234_ABCD, 32'h0,         2, 0, 1, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 0, 32'h0,         0, 4);
        add(SBYTE,      32'h301, 32'hFFFF_FF3C, 32'h0,         1, 0, 1, 1, 32'h300, 4'b0010, 32'h3C3C_3C3C, 0, 32'h0,         0, 3);
        add(LBYTE,      32'h102, 32'h0,         32'h0080_0000, 0, 0, 1, 0, 32'h100, 4'b0000, 32'h0,         1, 32'hFFFF_FF80, 0, 3);
        add(LBYTEU,     32'h102, 32'h0,         32'h0080_0000, 0, 0, 1, 0, 32'h100, 4'b0000, 32'h0,         1, 32'h0000_0080, 0, 3);
        add(LHALFWORD,  32'h102, 32'h0,         32'h8001_0000, 0, 0, 1, 0, 32'h100, 4'b0000, 32'h0,         1, 32'hFFFF_8001, 0, 3);
        add(LHALFWORDU, 32'h100, 32'h0,         32'h1234_8001, 1, 0, 1, 0, 32'h100, 4'b0000, 32'h0,         1, 32'h0000_8001, 0, 4);
        add(LWORD,      32'h104, 32'h0,         32'hCAFE_F00D, 0, 0, 1, 0, 32'h104, 4'b0000, 32'h0,         1, 32'hCAFE_F00D, 0, 3);
        add(LBYTE,      32'h101, 32'h0,         32'h0000_7F00, 0, 0, 1, 0, 32'h100, 4'b0000, 32'h0,         1, 32'h0000_007F, 0, 3);
        add(LWORD,      32'h101, 32'h0,         32'h0,         0, 1, 0, 0, 32'h0,   4'b0000, 32'h0,         0, 32'h0,         0, 0);
        add(SHALFWORD,  32'h103, 32'h0,         32'h0,         0, 1, 0, 1, 32'h0,   4'b0000, 32'h0,         0, 32'h0,         0, 0);
        add(5'd31,      32'h100, 32'h0,         32'h0,         0, 0, 0, 0, 32'h0,   4'b0000, 32'h0,         0, 32'h0,         0, 0);
        add(LWORD,      32'h108, 32'h0,         32'h0,        -1, 0, 1, 0, 32'h108, 4'b0000, 32'h0,         0, 32'h0,         1, 5);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", {29'h0, rdata_valid, misalign, bus_err}, 32'h0);
        chk("rst_dbus", {26'h0, dbus_if.dbus_req, dbus_if.dbus_we, dbus_if.dbus_be}, 32'h0);
        chk("rst_daddr", dbus_if.dbus_addr, 32'h0);
        chk("rst_dwdata", dbus_if.dbus_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Load to leave nonzero rdata, then reset during WAIT
        rv = vecs[8];
        run_vec(rv, 100);
        @(negedge clk);
        mem_op = LWORD;
        addr   = 32'h10C;
        @(negedge clk);
        dbus_if.dbus_gnt = 1'b1;
        #1;
        chk("mid_req", {31'h0, dbus_if.dbus_req}, 32'h1);
        @(negedge clk);
        dbus_if.dbus_gnt = 1'b0;
        #1;
        chk("mid_wait_stall", {31'h0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", {31'h0, stall}, 32'h0);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_flags", {28'h0, dbus_if.dbus_req, rdata_valid, misalign, bus_err}, 32'h0);
        chk("mid_rst_daddr", dbus_if.dbus_addr, 32'h0);
        @(negedge clk);
        mem_op = MEMOFF;
        rst_n  = 1'b1;
        run_vec(rv, 101);

        if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
